pipeline_sequencer: RTL and testbench
=====================================

# pipeline_sequencer

Sequencing controller for the 2-stage RV32I pipeline (fetch | decode-execute-writeback). It drives PC and instruction-register enables and the decoder `valid` qualifier, inserts a one-cycle bubble after taken branches and jumps, and stalls on data-memory accesses until the memory signals ready. It gates register writeback to retiring instructions, counts retired instructions and traps a hung memory with a sticky error.

## Interface
- `TIMEOUT_CYC`, default 16: maximum wait cycles per memory access; 0 disables the timeout.
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `next_sel` in 1: taken branch/jump from the control unit for the stage-2 instruction.
- `mem_en` in 1: stage-2 instruction is a load or store.
- `reg_write` in 1: stage-2 instruction writes the register file.
- `dmem_ready` in 1: data memory completes the current access this cycle.
- `pc_en` out 1: PC update enable.
- `ir_en` out 1: fetch/execute pipeline-register enable; always equal to `pc_en`.
- `valid` out 1: stage-2 instruction is real; drives the decoder `valid`.
- `dmem_req` out 1: data-memory request.
- `wb_en` out 1: register-file write enable, already gated.
- `mem_err` out 1: sticky memory-timeout flag.
- `instret` out CNT_W: retired-instruction count.

## Operation
- States: BOOT, RUN, MEM_WAIT, FLUSH, ERROR.
- `valid` = 1 in RUN and MEM_WAIT, 0 otherwise. It is decoded from the state register only.
- **Retire condition:**
  - In RUN: `valid & (~mem_en | dmem_ready)`.
  - In MEM_WAIT: `dmem_ready`.
  - `wb_en = reg_write & retire`.
  - `instret` increments by 1 on retire and wraps modulo 2^CNT_W.
- **BOOT:** `pc_en`=1, `valid`=0. Fetches the first instruction. Always goes to RUN next cycle.
- **RUN:**
  - `dmem_req = mem_en`.
  - `pc_en` = 1 unless (`mem_en & ~dmem_ready`).
  - `mem_en & ~dmem_ready` → MEM_WAIT; the wait counter loads 1.
  - Else `next_sel` → FLUSH.
  - Else stay in RUN.
- **MEM_WAIT:**
  - `dmem_req`=1 and `pc_en`=0. The stage-2 instruction is held.
  - `dmem_ready` → retire with `pc_en`=1. Then `next_sel` → FLUSH, otherwise → RUN.
  - Otherwise the counter increments. If the counter equals TIMEOUT_CYC and TIMEOUT_CYC≠0 → ERROR.
- **FLUSH:** `pc_en`=1, `valid`=0, `dmem_req`=0, `wb_en`=0. The wrong-path instruction is discarded. `next_sel` and `mem_en` are ignored. Always goes to RUN.
- **ERROR:** terminal until reset.
  - `mem_err`=1.
  - `pc_en`, `valid`, `dmem_req` and `wb_en` all 0.
  - `dmem_ready` is ignored.
- **Priority:** a memory stall resolves before a flush. `next_sel` is acted on only in the retire cycle.
- `dmem_ready` outside RUN+`mem_en` and MEM_WAIT is ignored.

## Timing
- **Reset values** (asynchronous, immediate, including mid-MEM_WAIT):
  - state = BOOT.
  - `pc_en`=0 while `rst` is high, then 1 in BOOT.
  - `valid`=0, `dmem_req`=0, `wb_en`=0, `mem_err`=0.
  - `instret`=0, wait counter = 0.
- Combinational (Mealy) outputs: `pc_en`, `ir_en`, `dmem_req`, `wb_en`.
- Registered outputs: `valid`, `mem_err`, `instret`; `instret` updates on the clock edge after the retire cycle.
- Zero-wait access: `dmem_ready` in the same cycle as `dmem_req` gives no stall.
- Taken branch/jump costs exactly one bubble cycle.
- A memory access with ready N cycles after the first request holds `pc_en` low for N cycles.
- Timeout: ERROR is entered on the edge after TIMEOUT_CYC consecutive non-ready wait cycles.
- Wait counter width is $clog2(TIMEOUT_CYC+1), minimum 1.

## Structure
- Shared package `pipe_pkg`: state encodings (BOOT=0, RUN=1, MEM_WAIT=2, FLUSH=3, ERROR=4), 3-bit state width, and the default TIMEOUT_CYC.
- One sub-module, `stall_timer`:
  - Inputs: `clk`, `rst`, `load`, `inc`, `limit`.
  - Output: `expired`.
  - Holds the wait counter and the TIMEOUT_CYC=0 disable.
- The FSM, output decode and `instret` live in the top module.

## Test plan
- **Reset:** assert `rst` for 3 cycles → all outputs 0, `instret`=0; first cycle after release is BOOT (`pc_en`=1, `valid`=0); next cycle is RUN with `valid`=1.
- **Three back-to-back ALU ops** (`mem_en`=0, `reg_write`=1, `next_sel`=0) → `wb_en` high 3 cycles, `pc_en` never drops, `instret`=3.
- **Load with `dmem_ready` 2 cycles after the request** → `pc_en`=0 for 2 cycles, `dmem_req` high 3 cycles, single `wb_en` pulse on the ready cycle, `instret` +1.
- **Taken branch** (`next_sel`=1, `reg_write`=0) → next cycle `valid`=0, `pc_en`=1, `wb_en`=0, `instret` unchanged; following cycle `valid`=1.
- **TIMEOUT_CYC=4, store with `dmem_ready` never asserted** → `mem_err`=1 after 4 wait cycles, all enables 0; a later `dmem_ready` has no effect; `rst` clears `mem_err`.
- **`rst` pulse mid-MEM_WAIT, plus store+`next_sel`** with ready on cycle 1 → FLUSH follows the retire cycle; the asynchronous reset returns the block to BOOT without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the 2-stage pipeline sequencer: state encodings,
// the default memory timeout and the wait-counter sizing helper.
package pipe_pkg;

  localparam int unsigned StateW            = 3;
  localparam int unsigned TimeoutCycDefault = 16;

  typedef enum logic [StateW-1:0] {
    StBoot    = 3'd0,
    StRun     = 3'd1,
    StMemWait = 3'd2,
    StFlush   = 3'd3,
    StError   = 3'd4
  } state_e;

  // The counter must hold the timeout value itself; a disabled timeout still needs one bit.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/stall_timer.sv
// Counts memory wait cycles and flags when the count reaches the limit.
// A limit of zero disables the timeout.
module stall_timer #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             inc,
  input  logic [WIDTH-1:0] limit,
  output logic             expired
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= WIDTH'(1);
    end else if (inc) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

  assign expired = (limit != '0) && (r_cnt == limit);

endmodule

// File: rtl/pipeline_sequencer.sv
// Sequencing controller for the fetch | decode-execute-writeback pipeline:
// PC/IR enables, branch bubbles, memory stalls, gated writeback and instret.
module pipeline_sequencer
  import pipe_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TimeoutCycDefault,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             next_sel,
  input  logic             mem_en,
  input  logic             reg_write,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ir_en,
  output logic             valid,
  output logic             dmem_req,
  output logic             wb_en,
  output logic             mem_err,
  output logic [CNT_W-1:0] instret
);

  localparam int unsigned WaitW = cnt_width(TIMEOUT_CYC);

  state_e           r_state;
  state_e           w_state_next;
  logic             w_pc_en;
  logic             w_retire;
  logic             w_load;
  logic             w_inc;
  logic             w_expired;
  logic [CNT_W-1:0] r_instret;

  stall_timer #(
    .WIDTH (WaitW)
  ) u_stall_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (w_load),
    .inc     (w_inc),
    .limit   (WaitW'(TIMEOUT_CYC)),
    .expired (w_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StBoot;
      r_instret <= '0;
    end else begin
      r_state   <= w_state_next;
      r_instret <= r_instret + CNT_W'(w_retire);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_en      = 1'b0;
    dmem_req     = 1'b0;
    w_retire     = 1'b0;
    w_load       = 1'b0;
    w_inc        = 1'b0;
    unique case (r_state)
      StBoot: begin
        w_pc_en      = 1'b1;
        w_state_next = StRun;
      end
      StRun: begin
        dmem_req = mem_en;
        if (mem_en && !dmem_ready) begin
          w_load       = 1'b1;
          w_state_next = StMemWait;
        end else begin
          w_pc_en  = 1'b1;
          w_retire = 1'b1;
          if (next_sel) w_state_next = StFlush;
        end
      end
      StMemWait: begin
        dmem_req = 1'b1;
        if (dmem_ready) begin
          w_pc_en      = 1'b1;
          w_retire     = 1'b1;
          w_state_next = next_sel ? StFlush : StRun;
        end else begin
          w_inc = 1'b1;
          if (w_expired) w_state_next = StError;
        end
      end
      StFlush: begin
        // Wrong-path instruction in stage 2 is dropped; its controls are ignored.
        w_pc_en      = 1'b1;
        w_state_next = StRun;
      end
      StError: begin
        w_state_next = StError;
      end
      default: begin
        w_state_next = StBoot;
      end
    endcase
  end

  // BOOT drives pc_en high, so hold it off explicitly while reset is asserted.
  assign pc_en   = w_pc_en & ~rst;
  assign ir_en   = pc_en;
  assign wb_en   = reg_write & w_retire;
  assign valid   = (r_state == StRun) || (r_state == StMemWait);
  assign mem_err = (r_state == StError);
  assign instret = r_instret;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer with a 4-cycle memory timeout.
module tb_pipeline_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        next_sel = 1'b0;
  logic        mem_en = 1'b0;
  logic        reg_write = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        pc_en;
  logic        ir_en;
  logic        valid;
  logic        dmem_req;
  logic        wb_en;
  logic        mem_err;
  logic [31:0] instret;

  int n_checks = 0;
  int n_errors = 0;

  pipeline_sequencer #(
    .TIMEOUT_CYC (4),
    .CNT_W       (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .next_sel   (next_sel),
    .mem_en     (mem_en),
    .reg_write  (reg_write),
    .dmem_ready (dmem_ready),
    .pc_en      (pc_en),
    .ir_en      (ir_en),
    .valid      (valid),
    .dmem_req   (dmem_req),
    .wb_en      (wb_en),
    .mem_err    (mem_err),
    .instret    (instret)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic ns, input logic me, input logic rw, input logic rdy);
    next_sel   = ns;
    mem_en     = me;
    reg_write  = rw;
    dmem_ready = rdy;
  endtask

  // Advance one clock, apply inputs just after the edge, sample at the falling edge.
  task automatic step(input logic ns, input logic me, input logic rw, input logic rdy);
    @(posedge clk);
    #1;
    drive(ns, me, rw, rdy);
    @(negedge clk);
  endtask

  task automatic check_ctl(input string tag, input logic e_pc, input logic e_valid,
                           input logic e_req, input logic e_wb);
    check({tag, ".pc_en"}, {31'd0, pc_en}, {31'd0, e_pc});
    check({tag, ".ir_en"}, {31'd0, ir_en}, {31'd0, e_pc});
    check({tag, ".valid"}, {31'd0, valid}, {31'd0, e_valid});
    check({tag, ".dmem_req"}, {31'd0, dmem_req}, {31'd0, e_req});
    check({tag, ".wb_en"}, {31'd0, wb_en}, {31'd0, e_wb});
  endtask

  int pc_low;
  int req_hi;
  int wb_hi;

  initial begin
    // Reset held 3 cycles with active-looking inputs that must be suppressed.
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset.mem_err", {31'd0, mem_err}, 32'd0);
    check("reset.instret", instret, 32'd0);

    #1;
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check_ctl("boot", 1'b1, 1'b0, 1'b0, 1'b0);

    // Three back-to-back ALU ops.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      check_ctl("alu", 1'b1, 1'b1, 1'b0, 1'b1);
    end

    // Load, ready two cycles after the first request.
    pc_low = 0;
    req_hi = 0;
    wb_hi  = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b1, (i == 2));
      if (i == 0) check("alu.instret", instret, 32'd3);
      check("load.valid", {31'd0, valid}, 32'd1);
      check("load.wb_en", {31'd0, wb_en}, {31'd0, (i == 2)});
      pc_low += !pc_en;
      req_hi += dmem_req;
      wb_hi  += wb_en;
    end
    check("load.pc_low_cycles", pc_low, 32'd2);
    check("load.req_cycles", req_hi, 32'd3);
    check("load.wb_pulses", wb_hi, 32'd1);

    // Taken branch: bubble cycle ignores its own controls, branch itself retires.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("branch.instret_before", instret, 32'd4);
    check_ctl("branch", 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check_ctl("flush", 1'b1, 1'b0, 1'b0, 1'b0);
    check("flush.instret", instret, 32'd5);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check_ctl("after_flush", 1'b1, 1'b1, 1'b0, 1'b0);
    check("after_flush.instret", instret, 32'd5);

    // Store with next_sel: stall wins, flush follows the retire cycle.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check_ctl("st_br.req", 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check_ctl("st_br.ready", 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check_ctl("st_br.flush", 1'b1, 1'b0, 1'b0, 1'b0);
    check("st_br.instret", instret, 32'd7);

    // Asynchronous reset in the middle of a memory wait.
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check_ctl("mw.pre_rst", 1'b0, 1'b1, 1'b1, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    check_ctl("mw.async_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    check("mw.async_rst.instret", instret, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check_ctl("mw.boot", 1'b1, 1'b0, 1'b0, 1'b0);

    // Store that never completes: four wait cycles, then ERROR.
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check_ctl("to.req", 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0);
      check("to.wait.mem_err", {31'd0, mem_err}, 32'd0);
      check("to.wait.pc_en", {31'd0, pc_en}, 32'd0);
    end
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check("to.err.mem_err", {31'd0, mem_err}, 32'd1);
    check_ctl("to.err", 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check_ctl("to.late_ready", 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check("to.sticky.mem_err", {31'd0, mem_err}, 32'd1);
    check("to.sticky.instret", instret, 32'd0);

    #1;
    rst = 1'b1;
    #1;
    check("to.rst.mem_err", {31'd0, mem_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check_ctl("to.boot", 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check_ctl("to.run", 1'b1, 1'b1, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
